pc_incrementer: RTL and testbench

- Next-sequential-address generator for the RV32IM single-cycle CPU fetch path.
- Produces PC + PC_STEP combinationally, so next-PC selection sees it in the same cycle.
- Also provides wrap-around and misalignment status.
- Also provides a registered copy of the result plus a wrap event counter for debug and trace use.

---
 rtl/pc_incrementer.sv | 122 ++++++++++++
 tb/tb_pc_incrementer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pc_incrementer.sv
// pc_incrementer
//   Next-sequential-address generator for the fetch path. It computes
//   PC + PC_STEP combinationally, so next-PC selection can use it in the same
//   cycle. It also reports address wrap-around and PC misalignment. For debug
//   and trace, it keeps a registered copy of the result and a saturating count
//   of captured wrap events.
//
// Ports
//   clk          in   1          clock, rising edge
//   rst          in   1          asynchronous reset, active high
//   PC           in   PC_WIDTH   current program counter
//   En           in   1          capture enable for the registered stage
//   PC_Plus_4    out  PC_WIDTH   (PC + PC_STEP) mod 2^PC_WIDTH, combinational
//   Wrap         out  1          carry-out of the addition, combinational
//   Misaligned   out  1          PC not a multiple of PC_STEP, combinational
//   PC_Plus_4_Q  out  PC_WIDTH   PC_Plus_4 captured on the last enabled edge
//   Valid_Q      out  1          PC_Plus_4_Q holds a captured value
//   Wrap_Count   out  CNT_WIDTH  captured wrap events, saturating

// Saturating event counter: increments on inc_i and sticks at all-ones.
module pc_inc_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

module pc_incrementer #(
  parameter int PC_WIDTH  = 32,
  parameter int PC_STEP   = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_WIDTH-1:0]  PC,
  input  logic                 En,
  output logic [PC_WIDTH-1:0]  PC_Plus_4,
  output logic                 Wrap,
  output logic                 Misaligned,
  output logic [PC_WIDTH-1:0]  PC_Plus_4_Q,
  output logic                 Valid_Q,
  output logic [CNT_WIDTH-1:0] Wrap_Count
);
  // The number of low PC bits that must be zero for an aligned PC.
  localparam int SH = $clog2(PC_STEP);

  // Reject illegal step values when the design is elaborated.
  if (PC_STEP < 1 || (PC_STEP & (PC_STEP - 1)) != 0 || SH >= PC_WIDTH) begin : g_bad_step
    $error("pc_incrementer: PC_STEP must be a power of two below 2^PC_WIDTH");
  end

  // ---------------------------------------------------------------------------
  // Combinational path. It is independent of clk, rst and En.
  // ---------------------------------------------------------------------------
  localparam logic [PC_WIDTH:0] STEP_EXT = (PC_WIDTH+1)'(PC_STEP);

  // One extra bit holds the carry. That carry is the wrap flag.
  logic [PC_WIDTH:0] sum;
  assign sum       = {1'b0, PC} + STEP_EXT;
  assign PC_Plus_4 = sum[PC_WIDTH-1:0];
  assign Wrap      = sum[PC_WIDTH];

  // With a step of 1, every address is aligned. This case is split out
  // because its alignment field would have zero width.
  if (SH == 0) begin : g_mis_none
    assign Misaligned = 1'b0;
  end else begin : g_mis_bits
    assign Misaligned = |PC[SH-1:0];
  end

  // ---------------------------------------------------------------------------
  // Registered debug/trace stage
  // ---------------------------------------------------------------------------
  logic [PC_WIDTH-1:0] pc_nxt_q, pc_nxt_d;
  logic                vld_q, vld_d;

  always_comb begin
    pc_nxt_d = pc_nxt_q;
    vld_d    = vld_q;
    if (En) begin
      pc_nxt_d = PC_Plus_4;
      vld_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_nxt_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      pc_nxt_q <= pc_nxt_d;
      vld_q    <= vld_d;
    end
  end

  // Count a wrap only when that edge also captures the result.
  pc_inc_sat_cnt #(.W(CNT_WIDTH)) u_wrap_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (En && Wrap),
    .cnt_o (Wrap_Count)
  );

  assign PC_Plus_4_Q = pc_nxt_q;
  assign Valid_Q     = vld_q;
endmodule

// File: tb/tb_pc_incrementer.sv
module tb_pc_incrementer;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        en;

  logic [31:0] a_nxt, a_nxt_q, b_nxt, b_nxt_q;
  logic        a_wrap, a_mis, a_vld, b_wrap, b_mis, b_vld;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Instance A uses the default parameters.
  pc_incrementer u_dut (
    .clk(clk), .rst(rst), .PC(pc), .En(en),
    .PC_Plus_4(a_nxt), .Wrap(a_wrap), .Misaligned(a_mis),
    .PC_Plus_4_Q(a_nxt_q), .Valid_Q(a_vld), .Wrap_Count(a_cnt)
  );

  // Instance B has a 2-bit counter, so it reaches saturation quickly.
  pc_incrementer #(.CNT_WIDTH(2)) u_dut_c2 (
    .clk(clk), .rst(rst), .PC(pc), .En(en),
    .PC_Plus_4(b_nxt), .Wrap(b_wrap), .Misaligned(b_mis),
    .PC_Plus_4_Q(b_nxt_q), .Valid_Q(b_vld), .Wrap_Count(b_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Combinational vector: apply PC, let it settle, then check the outputs.
  task automatic comb_vec(input logic [31:0] p, input logic [31:0] exp_nxt,
                          input logic exp_wrap, input logic exp_mis);
    pc = p;
    #5;
    chk($sformatf("nxt@%08h", p),  a_nxt,  exp_nxt);
    chk($sformatf("wrap@%08h", p), a_wrap, exp_wrap);
    chk($sformatf("mis@%08h", p),  a_mis,  exp_mis);
  endtask

  task automatic edge_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    pc  = 32'h0;
    #1;
    chk("rst_q",   a_nxt_q, 32'h0);
    chk("rst_vld", a_vld,   1'b0);
    chk("rst_cnt", a_cnt,   16'h0);

    // These vectors run while reset is held. The combinational path does not
    // depend on reset.
    comb_vec(32'h00000000, 32'h00000004, 1'b0, 1'b0);
    comb_vec(32'h00000008, 32'h0000000C, 1'b0, 1'b0);
    comb_vec(32'h12345678, 32'h1234567C, 1'b0, 1'b0);
    comb_vec(32'hABCDEF00, 32'hABCDEF04, 1'b0, 1'b0);
    comb_vec(32'h7FFFFFFC, 32'h80000000, 1'b0, 1'b0);
    comb_vec(32'hFFFFFFFC, 32'h00000000, 1'b1, 1'b0);
    comb_vec(32'h00000002, 32'h00000006, 1'b0, 1'b1);
    comb_vec(32'h00000010, 32'h00000014, 1'b0, 1'b0);
    comb_vec(32'hFFFFFFFE, 32'h00000002, 1'b1, 1'b1);

    // Release reset away from the active edge.
    @(negedge clk);
    rst = 1'b0;

    // Single capture
    pc = 32'h00000100;
    en = 1'b1;
    edge_n(1);
    chk("cap_q",   a_nxt_q, 32'h00000104);
    chk("cap_vld", a_vld,   1'b1);
    chk("cap_cnt", a_cnt,   16'h0);

    // Hold for three edges with En low.
    en = 1'b0;
    pc = 32'h00000200;
    edge_n(3);
    chk("hold_q",   a_nxt_q, 32'h00000104);
    chk("hold_vld", a_vld,   1'b1);
    chk("hold_nxt", a_nxt,   32'h00000204);

    // Wrap events
    pc = 32'hFFFFFFFC;
    en = 1'b1;
    edge_n(3);
    chk("wrap3_cnt",  a_cnt,   16'd3);
    chk("wrap3_c2",   b_cnt,   2'd3);
    chk("wrap3_q",    a_nxt_q, 32'h00000000);
    edge_n(2);
    chk("wrap5_cnt",  a_cnt,   16'd5);
    chk("wrap5_sat",  b_cnt,   2'd3);

    // A non-wrapping capture must not change the counter.
    pc = 32'h00000020;
    edge_n(1);
    chk("nowrap_cnt", a_cnt,   16'd5);
    chk("nowrap_q",   a_nxt_q, 32'h00000024);

    // Assert reset between edges while a capture is pending.
    pc = 32'h00000300;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_q",    a_nxt_q, 32'h0);
    chk("arst_vld",  a_vld,   1'b0);
    chk("arst_cnt",  a_cnt,   16'h0);
    chk("arst_c2",   b_cnt,   2'd0);
    pc = 32'h00000040;
    #1;
    chk("arst_nxt",  a_nxt,   32'h00000044);
    edge_n(1);
    chk("arst_hold_q",   a_nxt_q, 32'h0);
    chk("arst_hold_vld", a_vld,   1'b0);

    // After release with En low, no capture takes place.
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    edge_n(1);
    chk("post_vld", a_vld,   1'b0);
    chk("post_q",   a_nxt_q, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
